// File: rtl/palette_fetch.sv
// palette_fetch -- palette RAM lookup for a pixel pipeline, with a CPU write port.
//
// A 2**AW x 16 palette RAM is read once per pixel (ce_pix) and the 15-bit RGB
// word is split into three pw-bit components two ce_pix cycles later. The CPU
// writes bytes through a holding register. The write is slotted into a cycle
// where the pixel pipeline does not need the RAM (ce_pix=0). If the pipeline
// keeps the RAM busy for too long, the write is forced in and that pixel's read
// is skipped.
//
// Word format: [15] unused, [14:10] blue, [9:5] green, [4:0] red.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   ce_pix              pixel clock enable
//   pix_index [AW-1:0]  palette index of the current pixel
//   hblank, vblank      blanking inputs
//   cpu_addr [AW:0]     byte address (bit 0 = 0 -> high byte, 1 -> low byte)
//   cpu_din  [7:0]      write data
//   cpu_we              single-cycle write request
//   cpu_busy            write pending
//   cpu_ack             one-cycle write-complete pulse
//   out_red/green/blue  colour components (zero while blanked)
//   out_blank           blank flag aligned with the colour outputs
module palette_fetch #(
  parameter int AW = 11,
  parameter int pw = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic [AW-1:0] pix_index,
  input  logic          hblank,
  input  logic          vblank,
  input  logic [AW:0]   cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_we,
  output logic          cpu_busy,
  output logic          cpu_ack,
  output logic [pw-1:0] out_red,
  output logic [pw-1:0] out_green,
  output logic [pw-1:0] out_blue,
  output logic          out_blank
);

  localparam int DEPTH = 32'd1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } wr_state_t;

  wr_state_t     state;
  wr_state_t     state_next;
  logic          do_write;
  logic          rd_en;
  logic [AW:0]   hold_addr;
  logic [7:0]    hold_data;
  logic [2:0]    starve;

  // The RAM is kept as two byte lanes so that a write touches only one byte.
  logic [7:0]    ram_hi [DEPTH];
  logic [7:0]    ram_lo [DEPTH];
  logic [15:0]   rd_word;
  logic          blank1;

  // The pixel read is suppressed in the write cycle, so the RAM never sees a
  // read and a write together.
  assign rd_en = ce_pix & ~do_write;

  // Write controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Write controller next state. The write fires on the first idle pixel slot,
  // or is forced after four consecutive starved PEND cycles.
  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_we) begin
          state_next = PEND;
        end else begin
          state_next = IDLE;
        end
      end
      PEND: begin
        if (!ce_pix || (starve == 3'd4)) begin
          do_write   = 1'b1;
          state_next = DONE;
        end else begin
          state_next = PEND;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Holding register and starvation counter. A request is captured only in
  // IDLE, so cpu_we during PEND/DONE is dropped. The counter is held at zero
  // outside PEND, which clears it on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_addr <= {(AW+1){1'b0}};
      hold_data <= 8'h00;
      starve    <= 3'd0;
    end else begin
      if ((state == IDLE) && cpu_we) begin
        hold_addr <= cpu_addr;
        hold_data <= cpu_din;
      end
      if ((state == PEND) && !do_write) begin
        starve <= starve + 3'd1;
      end else begin
        starve <= 3'd0;
      end
    end
  end

  // Status outputs are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_busy <= 1'b0;
      cpu_ack  <= 1'b0;
    end else begin
      cpu_busy <= (state_next == PEND);
      cpu_ack  <= (state_next == DONE);
    end
  end

  // Palette RAM byte writes. There is no reset, so contents survive a reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      if (hold_addr[0]) begin
        ram_lo[hold_addr[AW:1]] <= hold_data;
      end else begin
        ram_hi[hold_addr[AW:1]] <= hold_data;
      end
    end
  end

  // Stage 1: RAM read and blank capture. On a forced write the previous word
  // is kept, while blank1 still follows the current pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_word <= 16'h0000;
      blank1  <= 1'b1;
    end else begin
      if (rd_en) begin
        rd_word <= {ram_hi[pix_index], ram_lo[pix_index]};
      end
      if (ce_pix) begin
        blank1 <= hblank | vblank;
      end
    end
  end

  // Stage 2: split the word into components, forcing black while blanked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_red   <= {pw{1'b0}};
      out_green <= {pw{1'b0}};
      out_blue  <= {pw{1'b0}};
      out_blank <= 1'b1;
    end else if (ce_pix) begin
      out_blank <= blank1;
      if (blank1) begin
        out_red   <= {pw{1'b0}};
        out_green <= {pw{1'b0}};
        out_blue  <= {pw{1'b0}};
      end else begin
        out_red   <= rd_word[pw-1:0];
        out_green <= rd_word[2*pw-1:pw];
        out_blue  <= rd_word[3*pw-1:2*pw];
      end
    end
  end

endmodule

// File: doc/palette_fetch.md
PALETTE_FETCH -- requirements
Module: palette_fetch

Interface
REQ-001 The block SHALL have parameter AW, default 11, giving palette index width (2**AW entries of 16 bits).
REQ-002 The block SHALL have parameter pw, default 5, giving colour component width; fixed at 5 by the word format.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset:
 - clk  in  1  single system clock.
 - reset  in  1  asynchronous reset, active-high.
REQ-004 The block SHALL have these video-side ports:
 - ce_pix  in  1  pixel clock enable.
 - pix_index  in  AW  palette index of the current pixel.
 - hblank  in  1  horizontal blanking.
 - vblank  in  1  vertical blanking.
REQ-005 The block SHALL have these CPU-side ports:
 - cpu_addr  in  AW+1  byte address; bit 0 = 0 selects the high byte [15:8], bit 0 = 1 selects the low byte [7:0].
 - cpu_din  in  8  write data.
 - cpu_we  in  1  single-cycle write request.
 - cpu_busy  out  1  write pending.
 - cpu_ack  out  1  one-cycle write-complete pulse.
REQ-006 The block SHALL have these outputs to the colour LUT:
 - out_red  out  pw  red component.
 - out_green  out  pw  green component.
 - out_blue  out  pw  blue component.
 - out_blank  out  1  delayed blank flag.

Function
REQ-007 Palette RAM SHALL be single-port, 2**AW x 16, with per-byte write enable; word format is bit 15 unused, [14:10] blue, [9:5] green, [4:0] red.
REQ-008 Stage 1 SHALL, on ce_pix=1, read RAM at pix_index and register blank1 = hblank OR vblank.
REQ-009 Stage 2 SHALL, on the next ce_pix=1, split the read word into out_red, out_green and out_blue, and copy blank1 to out_blank; when blank1=1 all three components SHALL be 0.
REQ-010 Latency SHALL be exactly 2 ce_pix-enabled cycles from pix_index to outputs; outputs SHALL hold while ce_pix=0.
REQ-011 The CPU write controller SHALL have states IDLE, PEND and DONE.
REQ-012 In IDLE, cpu_we=1 SHALL capture cpu_addr and cpu_din into a holding register and move to PEND; cpu_busy SHALL be 1 from the following cycle.
REQ-013 In PEND, the write SHALL execute on the first cycle with ce_pix=0; the block SHALL then move to DONE.
REQ-014 PEND SHALL include a starvation counter (3 bits); after 4 consecutive PEND cycles with ce_pix=1, the write SHALL execute on the next cycle regardless of ce_pix.
REQ-015 On a forced write cycle, stage 1 SHALL skip its RAM read and re-present the previously read word; blank1 SHALL still update.
REQ-016 DONE SHALL last one cycle with cpu_ack=1 and cpu_busy=0, then return to IDLE.
REQ-017 cpu_we asserted while in PEND or DONE SHALL be ignored; there is no queueing.
REQ-018 A write SHALL modify only the addressed byte; the other byte of the word SHALL be preserved.
REQ-019 Stage 1 SHALL never read a word in the same cycle it is written, so no read-during-write ambiguity exists.
REQ-020 The starvation counter SHALL clear on entry to PEND.

Reset
REQ-021 On reset the block SHALL set out_red, out_green and out_blue to 0, out_blank to 1, blank1 to 1, cpu_busy to 0 and cpu_ack to 0.
REQ-022 On reset the controller SHALL go to IDLE and the starvation counter SHALL clear.
REQ-023 Reset during PEND SHALL discard the pending write, leaving the RAM word unchanged.
REQ-024 Reset SHALL NOT clear palette RAM contents.
REQ-025 Release from reset SHALL take effect on the first clk edge after reset deasserts.

Verification
REQ-026 CPU writes addr 0x00A=0x7C, then 0x00B=0x1F, with ce_pix every other cycle -> word 5 = 0x7C1F; pix_index=5, no blank -> two ce_pix later R=31, G=0, B=31.
REQ-027 ce_pix held at 1, cpu_we addr 0x006 data 0x03 -> write forced on 5th busy cycle, then cpu_ack pulse; the output for the skipped read equals the prior pixel's colour.
REQ-028 hblank=1 with pix_index pointing to a nonzero entry -> after 2 ce_pix: out_red, out_green and out_blue = 0, out_blank=1.
REQ-029 Second cpu_we while cpu_busy=1 (addr 0x010, data 0xFF) -> RAM word 8 unchanged, exactly one cpu_ack for the first write.
REQ-030 Reset asserted mid-PEND for a write of 0x55 to addr 0x001 -> word 0 low byte keeps its old value; outputs 0, out_blank=1, cpu_busy=0 immediately.
REQ-031 Write high byte 0x12 to addr 0x020 after the word holds 0x3456 -> word 0x10 = 0x1256.
